// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg -- shared definitions for the byte-serial memory controller.
//   XLEN / BYTE_W : bus width and RAM byte width
//   state_e       : controller FSM state encoding
//   LEN_*         : mem_len encodings (11 is treated as a word)
//   len_to_n      : byte count for a length code
//   load_extend   : zero/sign extension of an assembled load
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // Number of RAM bytes moved for a length code; the unused code maps to a word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      LEN_WORD: n = 3'd4;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

  // Extend the low n bytes of raw to 32 bits, sign-extending when sgn is set.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                  input logic [2:0]      n,
                                                  input logic            sgn);
    logic [XLEN-1:0] r;
    case (n)
      3'd1:    r = {{24{sgn & raw[7]}}, raw[7:0]};
      3'd2:    r = {{16{sgn & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if -- bus bundle between the pipeline/RAM side and mem_ctrl.
//   Data port : mem_req, mem_we, mem_len, mem_signed, mem_addr, mem_wdata
//               -> mem_done, mem_rdata
//   Fetch port: if_req, if_addr, if_clear -> if_done, if_inst
//   RAM port  : mem_din -> mem_dout, mem_a, mem_wr
//   master = requesters + RAM (drive requests and mem_din)
//   slave  = mem_ctrl
// -----------------------------------------------------------------------------
interface mem_ctrl_if;

  logic                                     mem_req;
  logic                                     mem_we;
  logic [1:0]                               mem_len;
  logic                                     mem_signed;
  logic [mem_ctrl_pkg::XLEN-1:0]            mem_addr;
  logic [mem_ctrl_pkg::XLEN-1:0]            mem_wdata;
  logic                                     mem_done;
  logic [mem_ctrl_pkg::XLEN-1:0]            mem_rdata;

  logic                                     if_req;
  logic [mem_ctrl_pkg::XLEN-1:0]            if_addr;
  logic                                     if_clear;
  logic                                     if_done;
  logic [mem_ctrl_pkg::XLEN-1:0]            if_inst;

  logic [mem_ctrl_pkg::BYTE_W-1:0]          mem_din;
  logic [mem_ctrl_pkg::BYTE_W-1:0]          mem_dout;
  logic [mem_ctrl_pkg::XLEN-1:0]            mem_a;
  logic                                     mem_wr;

  modport master (
    output mem_req, mem_we, mem_len, mem_signed, mem_addr, mem_wdata,
    output if_req, if_addr, if_clear, mem_din,
    input  mem_done, mem_rdata, if_done, if_inst, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  mem_req, mem_we, mem_len, mem_signed, mem_addr, mem_wdata,
    input  if_req, if_addr, if_clear, mem_din,
    output mem_done, mem_rdata, if_done, if_inst, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- byte-serial memory controller shared by the MEM stage and fetch.
//   clk_in : sole clock
//   rst_in : asynchronous active-low reset
//   rdy_in : 1 = run, 0 = freeze every register
//   bus    : mem_ctrl_if.slave (data port, fetch port, RAM byte port)
// One request at a time; data requests win over fetches. Addresses are issued
// one byte per cycle (little-endian); read bytes come back one cycle after
// their address, so a load finishes one cycle later than a store of equal size.
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  mem_ctrl_if.slave   bus
);

  state_e            state_q,     state_d;
  logic [2:0]        cnt_q,       cnt_d;      // edges since acceptance
  logic [2:0]        n_q,         n_d;        // byte count of the transaction
  logic [XLEN-1:0]   base_q,      base_d;
  logic [XLEN-1:0]   wdata_q,     wdata_d;
  logic              fetch_q,     fetch_d;
  logic              signed_q,    signed_d;
  logic [XLEN-1:0]   rbuf_q,      rbuf_d;     // load assembly buffer
  logic [XLEN-1:0]   mem_a_q,     mem_a_d;
  logic [BYTE_W-1:0] mem_dout_q,  mem_dout_d;
  logic              mem_wr_q,    mem_wr_d;
  logic              mem_done_q,  mem_done_d;
  logic              if_done_q,   if_done_d;
  logic [XLEN-1:0]   mem_rdata_q, mem_rdata_d;
  logic [XLEN-1:0]   if_inst_q,   if_inst_d;
  logic [1:0]        rd_idx_s;                 // byte slot captured this edge

  // The byte arriving now belongs to the address issued two edges ago.
  assign rd_idx_s = cnt_q[1:0] - 2'd2;

  // Next-state, counters and registered outputs; everything holds while rdy_in is low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    fetch_d     = fetch_q;
    signed_d    = signed_q;
    rbuf_d      = rbuf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    mem_done_d  = mem_done_q;
    if_done_d   = if_done_q;
    mem_rdata_d = mem_rdata_q;
    if_inst_d   = if_inst_q;
    if (rdy_in) begin
      mem_wr_d   = 1'b0;
      mem_done_d = 1'b0;
      if_done_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_req) begin
            base_d   = bus.mem_addr;
            n_d      = len_to_n(bus.mem_len);
            signed_d = bus.mem_signed;
            wdata_d  = bus.mem_wdata;
            fetch_d  = 1'b0;
            cnt_d    = 3'd1;
            rbuf_d   = 32'd0;
            mem_a_d  = bus.mem_addr;
            if (bus.mem_we) begin
              state_d    = ST_WRITE;
              mem_dout_d = bus.mem_wdata[7:0];
              mem_wr_d   = 1'b1;
            end else begin
              state_d    = ST_READ;
            end
          end else if (bus.if_req) begin
            base_d   = bus.if_addr;
            n_d      = 3'd4;
            signed_d = 1'b0;
            fetch_d  = 1'b1;
            cnt_d    = 3'd1;
            rbuf_d   = 32'd0;
            mem_a_d  = bus.if_addr;
            state_d  = ST_READ;
          end else begin
            state_d  = ST_IDLE;
          end
        end
        ST_READ: begin
          if (fetch_q && bus.if_clear) begin
            state_d = ST_IDLE;
          end else begin
            if (cnt_q < n_q) begin
              mem_a_d = base_q + {29'd0, cnt_q};
            end else begin
              mem_a_d = mem_a_q;
            end
            if (cnt_q >= 3'd2) begin
              rbuf_d[{rd_idx_s, 3'b000} +: 8] = bus.mem_din;
            end else begin
              rbuf_d = rbuf_q;
            end
            if (cnt_q == n_q + 3'd1) begin
              state_d = ST_DONE;
              if (fetch_q) begin
                if_done_d = 1'b1;
                if_inst_d = rbuf_d;
              end else begin
                mem_done_d  = 1'b1;
                mem_rdata_d = load_extend(rbuf_d, n_q, signed_q);
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          if (cnt_q == n_q) begin
            state_d    = ST_DONE;
            mem_done_d = 1'b1;
          end else begin
            mem_a_d    = base_q + {29'd0, cnt_q};
            mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr_d   = 1'b1;
            cnt_d      = cnt_q + 3'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      fetch_q     <= 1'b0;
      signed_q    <= 1'b0;
      rbuf_q      <= 32'd0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      mem_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= 32'd0;
      if_inst_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      fetch_q     <= fetch_d;
      signed_q    <= signed_d;
      rbuf_q      <= rbuf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      mem_done_q  <= mem_done_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      if_inst_q   <= if_inst_d;
    end
  end

  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.if_done   = if_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_inst   = if_inst_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl -- directed self-checking bench for mem_ctrl.
// A behavioural RAM returns ram_rd(mem_a) one cycle after the address (held
// while rdy_in is low) and records every byte write.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   wr_cnt = 0;
  logic [7:0] wmem [0:255];

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  // 10 ns clock.
  always #5 clk_in = ~clk_in;

  // RAM contents seen by loads and fetches.
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    logic [7:0] d;
    case (a[7:0])
      8'h00: d = 8'h11;  8'h01: d = 8'h22;  8'h02: d = 8'h33;  8'h03: d = 8'h44;
      8'h40: d = 8'h80;
      8'h50: d = 8'h34;  8'h51: d = 8'h92;
      8'h60: d = 8'hEF;  8'h61: d = 8'hBE;  8'h62: d = 8'hAD;  8'h63: d = 8'hDE;
      8'hFE: d = 8'hAA;  8'hFF: d = 8'hBB;
      default: d = a[7:0] ^ 8'h5A;
    endcase
    return d;
  endfunction

  // RAM model: read data one cycle after the address, writes logged.
  always @(posedge clk_in) begin
    if (rdy_in) bus.mem_din <= ram_rd(bus.mem_a);
    if (bus.mem_wr) begin
      wmem[bus.mem_a[7:0]] <= bus.mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_mem(input logic we, input logic [1:0] len, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.mem_we     = we;
    bus.mem_len    = len;
    bus.mem_signed = sgn;
    bus.mem_addr   = addr;
    bus.mem_wdata  = wdata;
    bus.mem_req    = 1'b1;
  endtask

  // Tick until a done pulse; lat = k means seen after edge t0+k when called just after t0.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.mem_done || bus.if_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_mem(input logic we, input logic [1:0] len, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    set_mem(we, len, sgn, addr, wdata);
    tick();
    wait_done(lat);
    bus.mem_req = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    int seen;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'b00; bus.mem_signed = 1'b0;
    bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_clear = 1'b0;

    // Reset values
    rst_in = 1'b0;
    tick(); tick();
    chk("rst_mem_a",     bus.mem_a,             32'd0);
    chk("rst_mem_dout",  {24'd0, bus.mem_dout}, 32'd0);
    chk("rst_mem_rdata", bus.mem_rdata,         32'd0);
    chk("rst_if_inst",   bus.if_inst,           32'd0);
    chk("rst_mem_wr",    {31'd0, bus.mem_wr},   32'd0);
    chk("rst_mem_done",  {31'd0, bus.mem_done}, 32'd0);
    chk("rst_if_done",   {31'd0, bus.if_done},  32'd0);
    rst_in = 1'b1;
    tick();

    // Word load at 0x1000: addresses per cycle, done after edge t0+5
    set_mem(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0);
    tick();
    chk("ld_a0", bus.mem_a, 32'h1000);
    chk("ld_wr", {31'd0, bus.mem_wr}, 32'd0);
    tick(); chk("ld_a1", bus.mem_a, 32'h1001);
    tick(); chk("ld_a2", bus.mem_a, 32'h1002);
    tick(); chk("ld_a3", bus.mem_a, 32'h1003);
    chk("ld_done_early3", {31'd0, bus.mem_done}, 32'd0);
    tick(); chk("ld_done_early4", {31'd0, bus.mem_done}, 32'd0);
    tick(); chk("ld_done", {31'd0, bus.mem_done}, 32'd1);
    chk("ld_rdata", bus.mem_rdata, 32'h44332211);
    bus.mem_req = 1'b0;
    tick(); chk("ld_done_pulse", {31'd0, bus.mem_done}, 32'd0);

    // Byte / half loads, signed and unsigned
    run_mem(1'b0, 2'b00, 1'b1, 32'h40, 32'd0, lat);
    chk("sb_lat", lat, 32'd2);
    chk("sb_rdata", bus.mem_rdata, 32'hFFFFFF80);
    run_mem(1'b0, 2'b00, 1'b0, 32'h40, 32'd0, lat);
    chk("ub_rdata", bus.mem_rdata, 32'h00000080);
    run_mem(1'b0, 2'b01, 1'b1, 32'h50, 32'd0, lat);
    chk("sh_lat", lat, 32'd3);
    chk("sh_rdata", bus.mem_rdata, 32'hFFFF9234);
    run_mem(1'b0, 2'b01, 1'b0, 32'h50, 32'd0, lat);
    chk("uh_rdata", bus.mem_rdata, 32'h00009234);

    // Half store 0xBEEFCAFE at 0x20: two write cycles, DONE entered at t0+2
    set_mem(1'b1, 2'b01, 1'b0, 32'h20, 32'hBEEFCAFE);
    tick();
    chk("st_wr0",   {31'd0, bus.mem_wr},   32'd1);
    chk("st_a0",    bus.mem_a,             32'h20);
    chk("st_dout0", {24'd0, bus.mem_dout}, 32'hFE);
    tick();
    chk("st_wr1",   {31'd0, bus.mem_wr},   32'd1);
    chk("st_a1",    bus.mem_a,             32'h21);
    chk("st_dout1", {24'd0, bus.mem_dout}, 32'hCA);
    tick();
    chk("st_wr_off", {31'd0, bus.mem_wr},   32'd0);
    chk("st_done",   {31'd0, bus.mem_done}, 32'd1);
    bus.mem_req = 1'b0;
    tick();
    chk("st_done_pulse", {31'd0, bus.mem_done}, 32'd0);
    chk("st_wr_cnt", wr_cnt, 32'd2);
    chk("st_b20", {24'd0, wmem[8'h20]}, 32'hFE);
    chk("st_b21", {24'd0, wmem[8'h21]}, 32'hCA);
    chk("st_rdata_hold", bus.mem_rdata, 32'h00009234);

    // Length code 11 behaves as a word
    run_mem(1'b0, 2'b11, 1'b0, 32'h60, 32'd0, lat);
    chk("len11_lat", lat, 32'd5);
    chk("len11_rdata", bus.mem_rdata, 32'hDEADBEEF);

    // Data and fetch requested together: data first, fetch accepted after DONE
    set_mem(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 32'h60;
    tick();
    wait_done(lat);
    chk("arb_data_lat", lat, 32'd5);
    chk("arb_data_first", {31'd0, bus.mem_done}, 32'd1);
    chk("arb_no_if_done", {31'd0, bus.if_done}, 32'd0);
    bus.mem_req = 1'b0;
    tick();
    chk("arb_gap_a", bus.mem_a, 32'h1003);
    tick();
    chk("arb_fetch_a0", bus.mem_a, 32'h60);
    wait_done(lat);
    chk("arb_fetch_lat", lat, 32'd5);
    chk("arb_if_done", {31'd0, bus.if_done}, 32'd1);
    chk("arb_if_inst", bus.if_inst, 32'hDEADBEEF);
    chk("arb_fetch_no_mem_done", {31'd0, bus.mem_done}, 32'd0);
    bus.if_req = 1'b0;
    tick();

    // if_clear during the second byte of a fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h70;
    tick();
    tick();
    chk("clr_a1", bus.mem_a, 32'h71);
    bus.if_clear = 1'b1; bus.if_req = 1'b0;
    tick();
    chk("clr_if_done", {31'd0, bus.if_done}, 32'd0);
    chk("clr_a_frozen", bus.mem_a, 32'h71);
    bus.if_clear = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.if_done) seen = 1;
    end
    chk("clr_no_if_done", seen, 32'd0);
    run_mem(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, lat);
    chk("clr_next_lat", lat, 32'd5);
    chk("clr_next_rdata", bus.mem_rdata, 32'h44332211);

    // Three stall cycles mid word-load: done moves from t0+5 to t0+8
    set_mem(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0);
    tick(); tick(); tick();
    chk("stall_a_pre", bus.mem_a, 32'h1002);
    rdy_in = 1'b0;
    tick(); tick(); tick();
    chk("stall_a_frozen", bus.mem_a, 32'h1002);
    chk("stall_no_done", {31'd0, bus.mem_done}, 32'd0);
    rdy_in = 1'b1;
    wait_done(lat);
    chk("stall_lat_after_t0p5", lat, 32'd3);
    chk("stall_rdata", bus.mem_rdata, 32'h44332211);
    bus.mem_req = 1'b0;
    tick();

    // Address wrap past 0xFFFFFFFF
    set_mem(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'd0);
    tick(); chk("wrap_a0", bus.mem_a, 32'hFFFFFFFE);
    tick(); chk("wrap_a1", bus.mem_a, 32'hFFFFFFFF);
    tick(); chk("wrap_a2", bus.mem_a, 32'h00000000);
    tick(); chk("wrap_a3", bus.mem_a, 32'h00000001);
    wait_done(lat);
    chk("wrap_lat", lat, 32'd2);
    chk("wrap_rdata", bus.mem_rdata, 32'h2211BBAA);
    bus.mem_req = 1'b0;
    tick();

    // Reset in the middle of a word store
    set_mem(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678);
    tick();
    chk("rs_dout0", {24'd0, bus.mem_dout}, 32'h78);
    tick();
    chk("rs_dout1", {24'd0, bus.mem_dout}, 32'h56);
    rst_in = 1'b0;
    #1;
    chk("rs_wr_off", {31'd0, bus.mem_wr}, 32'd0);
    chk("rs_a_zero", bus.mem_a, 32'd0);
    chk("rs_rdata_zero", bus.mem_rdata, 32'd0);
    bus.mem_req = 1'b0;
    tick();
    rst_in = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.mem_done || bus.mem_wr) seen = 1;
    end
    chk("rs_no_done", seen, 32'd0);
    run_mem(1'b0, 2'b00, 1'b1, 32'h40, 32'd0, lat);
    chk("rs_resume_lat", lat, 32'd2);
    chk("rs_resume_rdata", bus.mem_rdata, 32'hFFFFFF80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
